// File: rtl/rv_pkg.sv
// Shared RV32I decode constants for the pipelined core.
package rv_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd3;

    // True when a 5-bit register address names an implemented register.
    function automatic logic reg_in_range(input logic [4:0] a, input int num_regs);
        return (int'(a) < num_regs);
    endfunction

endpackage

// File: rtl/register_file_bypass.sv
// Architectural register file with x0 hardwired to zero and write-through bypass.
module register_file_bypass
    import rv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [4:0]      i_raddr1,
    input  logic [4:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [XLEN-1:0] r_regs [NUM_REGS];
    logic            w_wr_ok;

    assign w_wr_ok = i_we && (i_waddr != 5'd0) && reg_in_range(i_waddr, NUM_REGS);

    // Storage: cleared on reset, written only for legal nonzero destinations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[i_waddr[AW-1:0]] <= i_wdata;
        end
    end

    // Read ports: zero for x0/out-of-range, bypass a same-cycle write.
    always_comb begin
        o_rdata1 = '0;
        o_rdata2 = '0;
        if ((i_raddr1 != 5'd0) && reg_in_range(i_raddr1, NUM_REGS)) begin
            o_rdata1 = (w_wr_ok && (i_waddr == i_raddr1)) ? i_wdata : r_regs[i_raddr1[AW-1:0]];
        end
        if ((i_raddr2 != 5'd0) && reg_in_range(i_raddr2, NUM_REGS)) begin
            o_rdata2 = (w_wr_ok && (i_waddr == i_raddr2)) ? i_wdata : r_regs[i_raddr2[AW-1:0]];
        end
    end

endmodule

// File: rtl/id_stage_pipelined.sv
// RV32I instruction-decode stage: decode, register read, load-use stall, ID/EX register.
module id_stage_pipelined
    import rv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_REGS    = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    input  logic [31:0]            if_instruction,
    input  logic [XLEN-1:0]        if_pc,
    output logic                   id_ready,
    input  logic                   ex_ready,
    input  logic                   flush,
    input  logic                   wb_write_enable,
    input  logic [4:0]             wb_write_address,
    input  logic [XLEN-1:0]        wb_write_data,
    output logic                   ex_valid,
    output logic [XLEN-1:0]        ex_pc,
    output logic [XLEN-1:0]        ex_read_data1,
    output logic [XLEN-1:0]        ex_read_data2,
    output logic [XLEN-1:0]        ex_immediate,
    output logic [4:0]             ex_rs1,
    output logic [4:0]             ex_rs2,
    output logic [4:0]             ex_rd,
    output logic [2:0]             ex_funct3,
    output logic [6:0]             ex_funct7,
    output logic                   ex_aluop1_source,
    output logic                   ex_aluop2_source,
    output logic                   ex_memory_read_enable,
    output logic                   ex_memory_write_enable,
    output logic [1:0]             ex_wb_reg_write_source,
    output logic                   ex_reg_write_enable,
    output logic                   ex_illegal,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    // Sign-extend a 32-bit immediate to the datapath width.
    function automatic logic [XLEN-1:0] sext_imm(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    logic [6:0]        w_opcode;
    logic [4:0]        w_rs1, w_rs2, w_rd;
    logic signed [31:0] w_imm32;
    logic              w_aluop1, w_aluop2, w_memr, w_memw, w_regw;
    logic              w_rs1_used, w_rs2_used, w_legal_op, w_bad_reg, w_illegal;
    logic [1:0]        w_wbsrc;
    logic [XLEN-1:0]   w_rdata1, w_rdata2;
    logic              w_hazard;

    logic                   r_valid_p1, r_aluop1_p1, r_aluop2_p1, r_memr_p1, r_memw_p1;
    logic                   r_regw_p1, r_illegal_p1;
    logic [XLEN-1:0]        r_pc_p1, r_rdata1_p1, r_rdata2_p1, r_imm_p1;
    logic [4:0]             r_rs1_p1, r_rs2_p1, r_rd_p1;
    logic [2:0]             r_f3_p1;
    logic [6:0]             r_f7_p1;
    logic [1:0]             r_wbsrc_p1;
    logic [STALL_CNT_W-1:0] r_stall;

    assign w_opcode = if_instruction[6:0];
    assign w_rd     = if_instruction[11:7];
    assign w_rs2    = if_instruction[24:20];
    assign w_rs1    = (w_opcode == OP_LUI) ? 5'd0 : if_instruction[19:15];

    // Opcode decode into immediate and control signals.
    always_comb begin
        w_imm32    = '0;
        w_aluop1   = 1'b0;
        w_aluop2   = 1'b1;
        w_memr     = 1'b0;
        w_memw     = 1'b0;
        w_regw     = 1'b0;
        w_wbsrc    = WB_ALU;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b0;
        w_legal_op = 1'b1;
        case (w_opcode)
            OP_R: begin
                w_aluop2 = 1'b0; w_rs2_used = 1'b1; w_regw = 1'b1;
            end
            OP_I: begin
                w_imm32 = {{20{if_instruction[31]}}, if_instruction[31:20]}; w_regw = 1'b1;
            end
            OP_L: begin
                w_imm32 = {{20{if_instruction[31]}}, if_instruction[31:20]};
                w_regw = 1'b1; w_memr = 1'b1; w_wbsrc = WB_MEM;
            end
            OP_JALR: begin
                w_imm32 = {{20{if_instruction[31]}}, if_instruction[31:20]};
                w_regw = 1'b1; w_wbsrc = WB_PC4;
            end
            OP_S: begin
                w_imm32 = {{20{if_instruction[31]}}, if_instruction[31:25], if_instruction[11:7]};
                w_rs2_used = 1'b1; w_memw = 1'b1;
            end
            OP_B: begin
                w_imm32 = {{19{if_instruction[31]}}, if_instruction[31], if_instruction[7],
                           if_instruction[30:25], if_instruction[11:8], 1'b0};
                w_rs2_used = 1'b1; w_aluop1 = 1'b1;
            end
            OP_LUI: begin
                w_imm32 = {if_instruction[31:12], 12'b0}; w_rs1_used = 1'b0; w_regw = 1'b1;
            end
            OP_AUIPC: begin
                w_imm32 = {if_instruction[31:12], 12'b0};
                w_rs1_used = 1'b0; w_regw = 1'b1; w_aluop1 = 1'b1;
            end
            OP_JAL: begin
                w_imm32 = {{11{if_instruction[31]}}, if_instruction[31], if_instruction[19:12],
                           if_instruction[20], if_instruction[30:21], 1'b0};
                w_rs1_used = 1'b0; w_regw = 1'b1; w_aluop1 = 1'b1; w_wbsrc = WB_PC4;
            end
            default: w_legal_op = 1'b0;
        endcase
    end

    // Only registers the instruction actually uses can make it illegal.
    assign w_bad_reg = (w_rs1_used && !reg_in_range(w_rs1, NUM_REGS)) ||
                       (w_rs2_used && !reg_in_range(w_rs2, NUM_REGS)) ||
                       (w_regw     && !reg_in_range(w_rd,  NUM_REGS));
    assign w_illegal = !w_legal_op || w_bad_reg;

    register_file_bypass #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .i_we     (wb_write_enable),
        .i_waddr  (wb_write_address),
        .i_wdata  (wb_write_data),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2)
    );

    assign w_hazard = if_valid && r_valid_p1 && r_memr_p1 && (r_rd_p1 != 5'd0) &&
                      ((w_rs1_used && (w_rs1 == r_rd_p1)) || (w_rs2_used && (w_rs2 == r_rd_p1)));
    assign id_ready = flush || (ex_ready && !w_hazard);

    // ---- ID / EX boundary ----
    // ID/EX register: flush beats bubble insertion beats normal advance; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_p1   <= 1'b0;
            r_pc_p1      <= '0;
            r_rdata1_p1  <= '0;
            r_rdata2_p1  <= '0;
            r_imm_p1     <= '0;
            r_rs1_p1     <= '0;
            r_rs2_p1     <= '0;
            r_rd_p1      <= '0;
            r_f3_p1      <= '0;
            r_f7_p1      <= '0;
            r_aluop1_p1  <= 1'b0;
            r_aluop2_p1  <= 1'b0;
            r_memr_p1    <= 1'b0;
            r_memw_p1    <= 1'b0;
            r_wbsrc_p1   <= '0;
            r_regw_p1    <= 1'b0;
            r_illegal_p1 <= 1'b0;
        end else if (flush) begin
            r_valid_p1 <= 1'b0;
        end else if (ex_ready && w_hazard) begin
            r_valid_p1 <= 1'b0;
        end else if (ex_ready) begin
            r_valid_p1   <= if_valid;
            r_pc_p1      <= if_pc;
            r_rdata1_p1  <= w_rdata1;
            r_rdata2_p1  <= w_rdata2;
            r_imm_p1     <= sext_imm(w_imm32);
            r_rs1_p1     <= w_rs1;
            r_rs2_p1     <= w_rs2;
            r_rd_p1      <= w_rd;
            r_f3_p1      <= if_instruction[14:12];
            r_f7_p1      <= if_instruction[31:25];
            r_aluop1_p1  <= w_aluop1;
            r_aluop2_p1  <= w_aluop2;
            r_memr_p1    <= w_memr;
            r_memw_p1    <= w_memw && !w_illegal;
            r_wbsrc_p1   <= w_wbsrc;
            r_regw_p1    <= w_regw && !w_illegal;
            r_illegal_p1 <= w_illegal;
        end
    end

    // Saturating count of cycles lost to load-use stalls (flushed cycles excluded).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if (w_hazard && !flush && (r_stall != '1)) begin
            r_stall <= r_stall + STALL_CNT_W'(1);
        end
    end

    assign ex_valid               = r_valid_p1;
    assign ex_pc                  = r_pc_p1;
    assign ex_read_data1          = r_rdata1_p1;
    assign ex_read_data2          = r_rdata2_p1;
    assign ex_immediate           = r_imm_p1;
    assign ex_rs1                 = r_rs1_p1;
    assign ex_rs2                 = r_rs2_p1;
    assign ex_rd                  = r_rd_p1;
    assign ex_funct3              = r_f3_p1;
    assign ex_funct7              = r_f7_p1;
    assign ex_aluop1_source       = r_aluop1_p1;
    assign ex_aluop2_source       = r_aluop2_p1;
    assign ex_memory_read_enable  = r_memr_p1;
    assign ex_memory_write_enable = r_memw_p1;
    assign ex_wb_reg_write_source = r_wbsrc_p1;
    assign ex_reg_write_enable    = r_regw_p1;
    assign ex_illegal             = r_illegal_p1;
    assign stall_cycles           = r_stall;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined: a 32-register and a 16-register instance.
module tb_id_stage_pipelined;

    logic        clk = 1'b0;
    logic        rst;
    int          n_vec = 0;
    int          n_err = 0;

    // 32-register instance
    logic        if_valid, ex_ready, flush, wb_we, id_ready;
    logic [31:0] if_instr, if_pc, wb_data;
    logic [4:0]  wb_addr;
    logic        ex_valid, ex_a1, ex_a2, ex_mr, ex_mw, ex_rw, ex_ill;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_f3;
    logic [6:0]  ex_f7;
    logic [1:0]  ex_wbs;
    logic [15:0] stall;

    // 16-register instance
    logic        b_if_valid, b_ex_ready, b_flush, b_wb_we, b_id_ready;
    logic [31:0] b_if_instr, b_if_pc, b_wb_data;
    logic [4:0]  b_wb_addr;
    logic        b_ex_valid, b_ex_a1, b_ex_a2, b_ex_mr, b_ex_mw, b_ex_rw, b_ex_ill;
    logic [31:0] b_ex_pc, b_ex_rd1, b_ex_rd2, b_ex_imm;
    logic [4:0]  b_ex_rs1, b_ex_rs2, b_ex_rd;
    logic [2:0]  b_ex_f3;
    logic [6:0]  b_ex_f7;
    logic [1:0]  b_ex_wbs;
    logic [15:0] b_stall;

    always #5 clk = ~clk;

    id_stage_pipelined dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instruction(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush),
        .wb_write_enable(wb_we), .wb_write_address(wb_addr), .wb_write_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_read_data1(ex_rd1), .ex_read_data2(ex_rd2),
        .ex_immediate(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_f3), .ex_funct7(ex_f7), .ex_aluop1_source(ex_a1), .ex_aluop2_source(ex_a2),
        .ex_memory_read_enable(ex_mr), .ex_memory_write_enable(ex_mw),
        .ex_wb_reg_write_source(ex_wbs), .ex_reg_write_enable(ex_rw), .ex_illegal(ex_ill),
        .stall_cycles(stall)
    );

    id_stage_pipelined #(.NUM_REGS(16)) dut16 (
        .clk(clk), .rst(rst), .if_valid(b_if_valid), .if_instruction(b_if_instr), .if_pc(b_if_pc),
        .id_ready(b_id_ready), .ex_ready(b_ex_ready), .flush(b_flush),
        .wb_write_enable(b_wb_we), .wb_write_address(b_wb_addr), .wb_write_data(b_wb_data),
        .ex_valid(b_ex_valid), .ex_pc(b_ex_pc), .ex_read_data1(b_ex_rd1), .ex_read_data2(b_ex_rd2),
        .ex_immediate(b_ex_imm), .ex_rs1(b_ex_rs1), .ex_rs2(b_ex_rs2), .ex_rd(b_ex_rd),
        .ex_funct3(b_ex_f3), .ex_funct7(b_ex_f7), .ex_aluop1_source(b_ex_a1), .ex_aluop2_source(b_ex_a2),
        .ex_memory_read_enable(b_ex_mr), .ex_memory_write_enable(b_ex_mw),
        .ex_wb_reg_write_source(b_ex_wbs), .ex_reg_write_enable(b_ex_rw), .ex_illegal(b_ex_ill),
        .stall_cycles(b_stall)
    );

    task automatic test_reset();
        rst = 1'b1;
        if_valid = 0; if_instr = 0; if_pc = 0; ex_ready = 1; flush = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0;
        b_if_valid = 0; b_if_instr = 0; b_if_pc = 0; b_ex_ready = 1; b_flush = 0;
        b_wb_we = 0; b_wb_addr = 0; b_wb_data = 0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_ex_valid got %0h want 0", ex_valid); end
        n_vec++; if (stall !== 16'd0) begin n_err++; $display("FAIL reset_stall got %0h want 0", stall); end
        n_vec++; if (ex_pc !== 32'd0) begin n_err++; $display("FAIL reset_ex_pc got %0h want 0", ex_pc); end
        n_vec++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL reset_id_ready got %0h want 1", id_ready); end
        n_vec++; if (b_ex_valid !== 1'b0) begin n_err++; $display("FAIL reset16_ex_valid got %0h want 0", b_ex_valid); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wb_then_read();
        @(negedge clk);
        wb_we = 1; wb_addr = 5'd5; wb_data = 32'h1234; if_valid = 0;
        @(negedge clk);
        wb_we = 0; if_valid = 1; if_instr = 32'h00528333; if_pc = 32'h100;  // add x6,x5,x5
        @(posedge clk); #1;
        n_vec++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %0h want 1", ex_valid); end
        n_vec++; if (ex_rd1 !== 32'h1234) begin n_err++; $display("FAIL add_rd1 got %0h want 1234", ex_rd1); end
        n_vec++; if (ex_rd2 !== 32'h1234) begin n_err++; $display("FAIL add_rd2 got %0h want 1234", ex_rd2); end
        n_vec++; if (ex_rd !== 5'd6) begin n_err++; $display("FAIL add_rd got %0d want 6", ex_rd); end
        n_vec++; if (ex_pc !== 32'h100) begin n_err++; $display("FAIL add_pc got %0h want 100", ex_pc); end
        n_vec++; if ({ex_a2, ex_rw, ex_ill} !== 3'b010) begin n_err++; $display("FAIL add_ctrl got %b want 010", {ex_a2, ex_rw, ex_ill}); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        wb_we = 1; wb_addr = 5'd7; wb_data = 32'hAAAA;
        if_valid = 1; if_instr = 32'hFFF38413; if_pc = 32'h104;             // addi x8,x7,-1
        @(posedge clk); #1;
        n_vec++; if (ex_rd1 !== 32'hAAAA) begin n_err++; $display("FAIL bypass_rd1 got %0h want aaaa", ex_rd1); end
        n_vec++; if (ex_imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL bypass_imm got %0h want ffffffff", ex_imm); end
        n_vec++; if (ex_rd !== 5'd8) begin n_err++; $display("FAIL bypass_rd got %0d want 8", ex_rd); end
        @(negedge clk);
        wb_we = 0;
    endtask

    task automatic test_decode();
        logic [31:0] ins [4];
        logic [31:0] eimm [4];
        logic [7:0]  ectl [4];
        logic [4:0]  ers1 [4];
        // sw x5,-4(x2); lui x9,0x12345; jal x1,+8; beq x1,x2,-16
        ins  = '{32'hFE512E23, 32'h123454B7, 32'h008000EF, 32'hFE2088E3};
        eimm = '{32'hFFFFFFFC, 32'h12345000, 32'h00000008, 32'hFFFFFFF0};
        // {aluop1, aluop2, memr, memw, wbsrc[1:0], regw, illegal}
        ectl = '{8'b01010000, 8'b01000010, 8'b11001110, 8'b11000000};
        ers1 = '{5'd2, 5'd0, 5'd0, 5'd1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if_valid = 1; if_instr = ins[i]; if_pc = 32'h180 + 32'(i * 4);
            @(posedge clk); #1;
            n_vec++; if (ex_imm !== eimm[i]) begin n_err++; $display("FAIL decode%0d_imm got %0h want %0h", i, ex_imm, eimm[i]); end
            n_vec++; if ({ex_a1, ex_a2, ex_mr, ex_mw, ex_wbs, ex_rw, ex_ill} !== ectl[i]) begin
                n_err++; $display("FAIL decode%0d_ctrl got %b want %b", i, {ex_a1, ex_a2, ex_mr, ex_mw, ex_wbs, ex_rw, ex_ill}, ectl[i]);
            end
            n_vec++; if (ex_rs1 !== ers1[i]) begin n_err++; $display("FAIL decode%0d_rs1 got %0d want %0d", i, ex_rs1, ers1[i]); end
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        if_valid = 1; if_instr = 32'h00012083; if_pc = 32'h200;              // lw x1,0(x2)
        #1;
        n_vec++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL lu_lw_ready got %0h want 1", id_ready); end
        @(negedge clk);
        if_instr = 32'h004081B3; if_pc = 32'h204;                           // add x3,x1,x4
        #1;
        n_vec++; if (id_ready !== 1'b0) begin n_err++; $display("FAIL lu_stall_ready got %0h want 0", id_ready); end
        @(posedge clk); #1;
        n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble got %0h want 0", ex_valid); end
        n_vec++; if (stall !== 16'd1) begin n_err++; $display("FAIL lu_stall_cnt got %0d want 1", stall); end
        @(negedge clk); #1;
        n_vec++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL lu_resume_ready got %0h want 1", id_ready); end
        @(posedge clk); #1;
        n_vec++; if ({ex_valid, ex_rd} !== {1'b1, 5'd3}) begin n_err++; $display("FAIL lu_add_issue got %b want 100011", {ex_valid, ex_rd}); end
        n_vec++; if (ex_pc !== 32'h204) begin n_err++; $display("FAIL lu_add_pc got %0h want 204", ex_pc); end
        n_vec++; if (stall !== 16'd1) begin n_err++; $display("FAIL lu_stall_after got %0d want 1", stall); end
    endtask

    task automatic test_flush_hazard();
        @(negedge clk);
        if_valid = 1; if_instr = 32'h00012083; if_pc = 32'h300;
        @(negedge clk);
        if_instr = 32'h004081B3; if_pc = 32'h304; flush = 1;
        #1;
        n_vec++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %0h want 1", id_ready); end
        @(posedge clk); #1;
        n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %0h want 0", ex_valid); end
        n_vec++; if (stall !== 16'd1) begin n_err++; $display("FAIL flush_stall got %0d want 1", stall); end
        @(negedge clk);
        flush = 0;
    endtask

    task automatic test_hold_async_reset();
        @(negedge clk);
        if_valid = 1; if_instr = 32'hFFF38413; if_pc = 32'h400; ex_ready = 1;
        @(posedge clk); #1;
        n_vec++; if ({ex_valid, ex_pc} !== {1'b1, 32'h400}) begin n_err++; $display("FAIL hold_load got %0h/%0h want 1/400", ex_valid, ex_pc); end
        @(negedge clk);
        ex_ready = 0; if_instr = 32'h00528333; if_pc = 32'h404;
        wb_we = 1; wb_addr = 5'd7; wb_data = 32'h5555;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++; if (id_ready !== 1'b0) begin n_err++; $display("FAIL hold%0d_ready got %0h want 0", c, id_ready); end
            @(posedge clk); #1;
            n_vec++; if ({ex_valid, ex_pc, ex_imm, ex_rd1, ex_rd} !== {1'b1, 32'h400, 32'hFFFFFFFF, 32'hAAAA, 5'd8}) begin
                n_err++; $display("FAIL hold%0d_payload got %0h %0h %0h %0h %0d want 1 400 ffffffff aaaa 8", c, ex_valid, ex_pc, ex_imm, ex_rd1, ex_rd);
            end
            @(negedge clk);
        end
        wb_we = 0;
        #2 rst = 1'b1;
        #1;
        n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_valid got %0h want 0", ex_valid); end
        n_vec++; if (stall !== 16'd0) begin n_err++; $display("FAIL async_rst_stall got %0d want 0", stall); end
        @(negedge clk);
        rst = 1'b0; ex_ready = 1; if_valid = 0;
    endtask

    task automatic test_small_rf();
        @(negedge clk);
        b_wb_we = 1; b_wb_addr = 5'd20; b_wb_data = 32'h5555; b_if_valid = 0;
        @(negedge clk);
        b_wb_addr = 5'd3; b_wb_data = 32'h77;
        @(negedge clk);
        b_wb_addr = 5'd20; b_wb_data = 32'h6666;
        b_if_valid = 1; b_if_instr = 32'h000A0093; b_if_pc = 32'h10;         // addi x1,x20,0
        @(posedge clk); #1;
        n_vec++; if (b_ex_rd1 !== 32'd0) begin n_err++; $display("FAIL rf16_x20_read got %0h want 0", b_ex_rd1); end
        n_vec++; if ({b_ex_valid, b_ex_ill, b_ex_rw} !== 3'b110) begin n_err++; $display("FAIL rf16_x20_ctrl got %b want 110", {b_ex_valid, b_ex_ill, b_ex_rw}); end
        @(negedge clk);
        b_wb_we = 0; b_if_instr = 32'h00018113;                             // addi x2,x3,0
        @(posedge clk); #1;
        n_vec++; if (b_ex_rd1 !== 32'h77) begin n_err++; $display("FAIL rf16_x3_read got %0h want 77", b_ex_rd1); end
        n_vec++; if ({b_ex_ill, b_ex_rw} !== 2'b01) begin n_err++; $display("FAIL rf16_x3_ctrl got %b want 01", {b_ex_ill, b_ex_rw}); end
        @(negedge clk);
        b_if_instr = 32'h00100893;                                          // addi x17,x0,1
        @(posedge clk); #1;
        n_vec++; if ({b_ex_ill, b_ex_rw} !== 2'b10) begin n_err++; $display("FAIL rf16_x17_ctrl got %b want 10", {b_ex_ill, b_ex_rw}); end
        @(negedge clk);
        b_if_instr = 32'h0000007F;                                          // unknown opcode
        @(posedge clk); #1;
        n_vec++; if ({b_ex_ill, b_ex_rw, b_ex_mw} !== 3'b100) begin n_err++; $display("FAIL rf16_op7f_ctrl got %b want 100", {b_ex_ill, b_ex_rw, b_ex_mw}); end
        @(negedge clk);
        b_if_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_wb_then_read();
        test_bypass();
        test_decode();
        test_load_use();
        test_flush_hazard();
        test_hold_async_reset();
        test_small_rf();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
